// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared widths and grant-owner encoding for the port-B arbiter
// Purpose: one place for the RAM port-B address/data widths, the starve counter
//          width and the owner encoding used by the arbiter and its users.
// Ports:   none (package).
package ram_arb_pkg;

  localparam int unsigned ADDR_W   = 12;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned STARVE_W = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VGA  = 2'd1,
    OWN_HOST = 2'd2
  } owner_e;

endpackage

// File: rtl/ram_portb_arbiter_if.sv
// rtl/ram_portb_arbiter_if.sv - bundle of the requester and RAM port-B signals
// Purpose: groups the VGA/host request channels and the RAM port-B bus so a
//          requester-side block and the arbiter can be wired as one bundle.
// Ports:   none; modport master = requester/RAM side, slave = arbiter side.
interface ram_portb_arbiter_if;
  import ram_arb_pkg::*;

  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_ack;
  logic              vga_valid;
  logic [DATA_W-1:0] vga_rdata;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ack;
  logic              host_valid;
  logic [DATA_W-1:0] host_rdata;

  logic [ADDR_W-1:0] ram_addr_b;
  logic [DATA_W-1:0] ram_data_b;
  logic              ram_we_b;
  logic [DATA_W-1:0] ram_q_b;

  modport master (
    output vga_req, vga_addr, host_req, host_we, host_addr, host_wdata, ram_q_b,
    input  vga_ack, vga_valid, vga_rdata, host_ack, host_valid, host_rdata,
    input  ram_addr_b, ram_data_b, ram_we_b
  );

  modport slave (
    input  vga_req, vga_addr, host_req, host_we, host_addr, host_wdata, ram_q_b,
    output vga_ack, vga_valid, vga_rdata, host_ack, host_valid, host_rdata,
    output ram_addr_b, ram_data_b, ram_we_b
  );

endinterface

// File: rtl/arb_starve_counter.sv
// rtl/arb_starve_counter.sv - counts host-denied cycles and forces a host grant
// Purpose: counts consecutive cycles where the host requests but is not granted,
//          saturating at STARVE_MAX; force_host is raised once the count reaches it.
// Ports:   clock, Reset (async, active-low); host_req, host_ack in;
//          force_host out (combinational from the registered count).
module arb_starve_counter
  import ram_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic clock,
  input  logic Reset,
  input  logic host_req,
  input  logic host_ack,
  output logic force_host
);

  localparam logic [STARVE_W-1:0] MAX_CNT = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] count_q;
  logic [STARVE_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (!host_req || host_ack) begin
      count_d = '0;
    end else if (count_q < MAX_CNT) begin
      count_d = count_q + STARVE_W'(1);
    end
  end

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Depends only on registered state, so the grant logic has no loop through it.
  assign force_host = (count_q == MAX_CNT);

endmodule

// File: rtl/ram_portb_arbiter.sv
// rtl/ram_portb_arbiter.sv - two-requester arbiter for the shared RAM port B
// Purpose: grants VGA reads or host reads/writes one per cycle onto RAM port B,
//          VGA first unless the host has starved for STARVE_MAX cycles; returns
//          read data with a one-cycle valid pulse to the owner of the grant.
// Ports:   clock, Reset (async, active-low);
//          vga_req/vga_addr in, vga_ack/vga_valid/vga_rdata out;
//          host_req/host_we/host_addr/host_wdata in, host_ack/host_valid/host_rdata out;
//          ram_addr_b/ram_data_b/ram_we_b out, ram_q_b in (1-cycle registered read).
module ram_portb_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic              clock,
  input  logic              Reset,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_ack,
  output logic              vga_valid,
  output logic [DATA_W-1:0] vga_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic              host_valid,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] ram_addr_b,
  output logic [DATA_W-1:0] ram_data_b,
  output logic              ram_we_b,
  input  logic [DATA_W-1:0] ram_q_b
);

  owner_e            owner_q, owner_d;
  logic              host_we_q, host_we_d;
  logic [DATA_W-1:0] vga_rdata_q, vga_rdata_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
  logic              force_host;
  logic              host_rd_done;

  arb_starve_counter #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clock      (clock),
    .Reset      (Reset),
    .host_req   (host_req),
    .host_ack   (host_ack),
    .force_host (force_host)
  );

  // Grant decision and port-B drive for the current cycle.
  always_comb begin
    host_ack   = host_req && (!vga_req || force_host);
    vga_ack    = vga_req && !host_ack;
    owner_d    = OWN_NONE;
    host_we_d  = 1'b0;
    ram_addr_b = '0;
    ram_data_b = '0;
    ram_we_b   = 1'b0;
    if (host_ack) begin
      owner_d    = OWN_HOST;
      host_we_d  = host_we;
      ram_addr_b = host_addr;
      ram_data_b = host_we ? host_wdata : '0;
      ram_we_b   = host_we;
    end else if (vga_ack) begin
      owner_d    = OWN_VGA;
      ram_addr_b = vga_addr;
    end
  end

  // Response side: the registered owner selects who sees ram_q_b this cycle.
  always_comb begin
    vga_valid    = (owner_q == OWN_VGA);
    host_valid   = (owner_q == OWN_HOST);
    host_rd_done = host_valid && !host_we_q;
    vga_rdata    = vga_valid ? ram_q_b : vga_rdata_q;
    host_rdata   = host_rd_done ? ram_q_b : host_rdata_q;
    vga_rdata_d  = vga_rdata;
    host_rdata_d = host_rdata;
  end

  // Async clear drops any read in flight: owner returns to NONE at once.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      owner_q      <= OWN_NONE;
      host_we_q    <= 1'b0;
      vga_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      owner_q      <= owner_d;
      host_we_q    <= host_we_d;
      vga_rdata_q  <= vga_rdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end

endmodule

// File: tb/tb_ram_portb_arbiter.sv
// tb/tb_ram_portb_arbiter.sv - scoreboard bench for the port-B arbiter
module tb_ram_portb_arbiter;
  import ram_arb_pkg::*;

  localparam int unsigned STARVE = 8;

  logic clock;
  logic Reset;
  int   cyc;
  int   checks;
  int   errors;

  ram_portb_arbiter_if bus ();

  ram_portb_arbiter #(.STARVE_MAX(STARVE)) dut (
    .clock      (clock),
    .Reset      (Reset),
    .vga_req    (bus.vga_req),
    .vga_addr   (bus.vga_addr),
    .vga_ack    (bus.vga_ack),
    .vga_valid  (bus.vga_valid),
    .vga_rdata  (bus.vga_rdata),
    .host_req   (bus.host_req),
    .host_we    (bus.host_we),
    .host_addr  (bus.host_addr),
    .host_wdata (bus.host_wdata),
    .host_ack   (bus.host_ack),
    .host_valid (bus.host_valid),
    .host_rdata (bus.host_rdata),
    .ram_addr_b (bus.ram_addr_b),
    .ram_data_b (bus.ram_data_b),
    .ram_we_b   (bus.ram_we_b),
    .ram_q_b    (bus.ram_q_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // RAM port B: synchronous write, registered read of the old contents.
  logic [15:0] ram_mem [4096];
  always @(posedge clock) begin
    if (bus.ram_we_b) ram_mem[bus.ram_addr_b] <= bus.ram_data_b;
    bus.ram_q_b <= ram_mem[bus.ram_addr_b];
  end

  // Reference model state
  typedef struct {
    int          owner;
    bit          we;
    logic [15:0] data;
    int          tag;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model_mem [4096];
  int          starve;
  bit          running;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input bit vr, input logic [11:0] va, input bit hr, input bit hw,
                      input logic [11:0] ha, input logic [15:0] hd,
                      output bit vg, output bit hg);
    logic [11:0] ea;
    logic [15:0] ed;
    @(posedge clock);
    #1;
    bus.vga_req    = vr;
    bus.vga_addr   = va;
    bus.host_req   = hr;
    bus.host_we    = hw;
    bus.host_addr  = ha;
    bus.host_wdata = hd;
    #2;
    hg = hr && (!vr || starve == int'(STARVE));
    vg = vr && !hg;
    ea = hg ? ha : (vg ? va : 12'h000);
    ed = (hg && hw) ? hd : 16'h0000;
    chk("vga_ack", 32'(bus.vga_ack), 32'(vg));
    chk("host_ack", 32'(bus.host_ack), 32'(hg));
    chk("ram_we_b", 32'(bus.ram_we_b), 32'(hg && hw));
    chk("ram_addr_b", 32'(bus.ram_addr_b), 32'(ea));
    chk("ram_data_b", 32'(bus.ram_data_b), 32'(ed));
    if (vg) sb.push_back('{1, 1'b0, model_mem[va], cyc});
    if (hg) begin
      if (hw) begin
        model_mem[ha] = hd;
        sb.push_back('{2, 1'b1, 16'h0000, cyc});
      end else begin
        sb.push_back('{2, 1'b0, model_mem[ha], cyc});
      end
    end
    if (hr && !hg) starve = (starve < int'(STARVE)) ? starve + 1 : starve;
    else starve = 0;
  endtask

  // Monitor: pops the expectation for last cycle's grant whenever valid appears.
  logic [15:0] mv_last, mh_last;
  always @(negedge clock) begin
    bit   due;
    exp_t e;
    if (running) begin
      if (!Reset) begin
        mv_last = 16'h0000;
        mh_last = 16'h0000;
      end
      due = (sb.size() > 0) && (sb[0].tag == cyc - 1);
      e   = '{0, 1'b0, 16'h0000, 0};
      if (due) e = sb.pop_front();
      chk("vga_valid", 32'(bus.vga_valid), 32'(due && e.owner == 1));
      chk("host_valid", 32'(bus.host_valid), 32'(due && e.owner == 2));
      if (due && e.owner == 1) mv_last = e.data;
      if (due && e.owner == 2 && !e.we) mh_last = e.data;
      chk("vga_rdata", 32'(bus.vga_rdata), 32'(mv_last));
      chk("host_rdata", 32'(bus.host_rdata), 32'(mh_last));
    end
  end

  initial begin
    bit vg, hg;
    bit vp, hp, hw;
    logic [11:0] va, ha;
    logic [15:0] hd;
    int first_host;

    checks = 0;
    errors = 0;
    cyc = 0;
    starve = 0;
    mv_last = 16'h0000;
    mh_last = 16'h0000;
    running = 1'b0;
    Reset = 1'b0;
    bus.vga_req = 1'b0;
    bus.vga_addr = '0;
    bus.host_req = 1'b0;
    bus.host_we = 1'b0;
    bus.host_addr = '0;
    bus.host_wdata = '0;
    bus.ram_q_b = '0;
    for (int i = 0; i < 4096; i++) begin
      ram_mem[i]   = 16'(i * 37 + 16'h1205);
      model_mem[i] = 16'(i * 37 + 16'h1205);
    end
    #2;
    running = 1'b1;
    chk("reset_vga_valid", 32'(bus.vga_valid), 32'd0);
    chk("reset_host_rdata", 32'(bus.host_rdata), 32'd0);
    repeat (2) @(posedge clock);
    #1 Reset = 1'b1;

    // VGA burst of three consecutive addresses
    step(1, 12'h010, 0, 0, 12'h000, 16'h0000, vg, hg);
    step(1, 12'h011, 0, 0, 12'h000, 16'h0000, vg, hg);
    step(1, 12'h012, 0, 0, 12'h000, 16'h0000, vg, hg);
    step(0, 12'h000, 0, 0, 12'h000, 16'h0000, vg, hg);

    // Host write followed directly by read of the same address
    step(0, 12'h000, 1, 1, 12'h100, 16'hBEEF, vg, hg);
    step(0, 12'h000, 1, 0, 12'h100, 16'h0000, vg, hg);
    step(0, 12'h000, 0, 0, 12'h000, 16'h0000, vg, hg);

    // Contention with a fresh count: VGA wins
    step(1, 12'h020, 1, 0, 12'h030, 16'h0000, vg, hg);
    step(1, 12'h021, 0, 0, 12'h000, 16'h0000, vg, hg);
    step(0, 12'h000, 0, 0, 12'h000, 16'h0000, vg, hg);

    // Starvation: host forced on the 9th contended cycle
    first_host = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1, 12'(12'h040 + i), 1, 0, 12'h050, 16'h0000, vg, hg);
      if (bus.host_ack && first_host == 0) first_host = i;
    end
    chk("starve_first_host_grant", 32'(first_host), 32'd9);
    step(0, 12'h000, 0, 0, 12'h000, 16'h0000, vg, hg);

    // Build some starve count, grant a VGA read, then reset before its data returns
    for (int i = 0; i < 4; i++) step(1, 12'h060, 1, 1, 12'h070, 16'h1234, vg, hg);
    #1;
    Reset = 1'b0;
    bus.vga_req = 1'b0;
    bus.host_req = 1'b0;
    sb.delete();
    starve = 0;
    repeat (2) @(posedge clock);
    #3;
    chk("rst_vga_rdata", 32'(bus.vga_rdata), 32'd0);
    chk("rst_vga_valid", 32'(bus.vga_valid), 32'd0);
    #1 Reset = 1'b1;
    for (int i = 0; i < 10; i++) step(1, 12'(12'h080 + i), 1, 0, 12'h090, 16'h0000, vg, hg);
    step(0, 12'h000, 0, 0, 12'h000, 16'h0000, vg, hg);

    // Randomised traffic; requesters hold their request until acked
    vp = 0;
    hp = 0;
    hw = 0;
    va = '0;
    ha = '0;
    hd = '0;
    for (int n = 0; n < 400; n++) begin
      if (!vp && $urandom_range(0, 2) != 0) begin
        vp = 1;
        va = 12'($urandom_range(0, 15));
      end
      if (!hp && $urandom_range(0, 1) != 0) begin
        hp = 1;
        hw = 1'($urandom_range(0, 1));
        ha = 12'($urandom_range(0, 15));
        hd = 16'($urandom);
      end
      step(vp, va, hp, hw, ha, hd, vg, hg);
      if (vg) vp = 0;
      if (hg) hp = 0;
    end
    step(0, 12'h000, 0, 0, 12'h000, 16'h0000, vg, hg);
    step(0, 12'h000, 0, 0, 12'h000, 16'h0000, vg, hg);
    @(posedge clock);
    #7;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    running = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
